// File: rtl/u74hc595_if.sv
// Pin bundle for the 74HC595 model: serial/control inputs and the cascade output.
// The tristated parallel bus q is a plain port on the chip model.
interface u74hc595_if;
  logic ds;
  logic shcp;
  logic stcp;
  logic mr_n;
  logic oe_n;
  logic q7s;

  modport master (output ds, shcp, stcp, mr_n, oe_n, input q7s);
  modport slave  (input ds, shcp, stcp, mr_n, oe_n, output q7s);
endinterface

// File: rtl/u74hc595_sr.sv
// Cycle-based 74HC595: sampled-pin edge detection, shift and storage registers,
// and a DELAY-deep output pipeline feeding the tristated q bus and q7s.
module u74hc595_sr #(
  parameter int unsigned DELAY = 9,
  parameter logic [7:0]  IC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vcc,
  input  logic       gnd,
  u74hc595_if.slave  pins,
  output wire  [7:0] q
);

  localparam int unsigned W  = 8;
  localparam int unsigned PW = W + 1;

  logic          vrst_n;
  logic          gnd_unused;
  logic [W-1:0]  sr_q, sr_d;
  logic [W-1:0]  st_q, st_d;
  logic          shcp_q, stcp_q;
  logic          shcp_rise_c, stcp_rise_c;
  logic [PW-1:0] tail_c;

  // A dead supply behaves exactly like a held reset.
  assign vrst_n     = rst_n & vcc;
  assign gnd_unused = gnd;

  // Edge detect on sampled pins; mr_n beats a coincident shift, storage takes the pre-shift value.
  always_comb begin
    shcp_rise_c = pins.shcp & ~shcp_q;
    stcp_rise_c = pins.stcp & ~stcp_q;
    sr_d        = sr_q;
    st_d        = st_q;
    if (!pins.mr_n) begin
      sr_d = '0;
    end else if (shcp_rise_c) begin
      sr_d = {sr_q[W-2:0], pins.ds};
    end
    if (stcp_rise_c) begin
      st_d = sr_q;
    end
  end

  // History regs reset high so a pin already high at release is not an edge.
  always_ff @(posedge clk or negedge vrst_n) begin
    if (!vrst_n) begin
      sr_q   <= '0;
      st_q   <= IC;
      shcp_q <= 1'b1;
      stcp_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      st_q   <= st_d;
      shcp_q <= pins.shcp;
      stcp_q <= pins.stcp;
    end
  end

  if (DELAY == 0) begin : g_direct
    assign tail_c = {st_q, sr_q[W-1]};
  end else begin : g_pipe
    logic [PW-1:0] pipe_q [DELAY];

    always_ff @(posedge clk or negedge vrst_n) begin
      if (!vrst_n) begin
        for (int unsigned i = 0; i < DELAY; i++) begin
          pipe_q[i] <= {IC, 1'b0};
        end
      end else begin
        pipe_q[0] <= {st_q, sr_q[W-1]};
        for (int unsigned i = 1; i < DELAY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign tail_c = pipe_q[DELAY-1];
  end

  // Output enable acts immediately; only the data path is delayed.
  assign q         = pins.oe_n ? 'z : tail_c[PW-1:1];
  assign pins.q7s  = tail_c[0];

endmodule
